neuron_weight_reader: RTL and testbench
=======================================

# neuron_weight_reader

Single-neuron weight reader and multiply-accumulate engine for the fully connected layers. It accepts one input activation per handshake and issues a read to the registered-output weight memory at the matching address. It multiplies each returned weight with the aligned activation and accumulates the products. After `numWeight` inputs it emits one saturated fixed-point neuron sum, which the activation stage consumes.

## Interface
- `numWeight`, 30: inputs/weights per neuron.
- `addressWidth`, `$clog2(numWeight)`: weight address width.
- `dataWidth`, 16: signed two's-complement width of activations, weights and result.
- `fracBits`, 12: fractional bits of the fixed-point format; 1.0 = `0x1000` at defaults.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `start` in 1: begin a new neuron evaluation; sampled only in IDLE.
- `in_valid` in 1: activation valid.
- `in_data` in `dataWidth`: signed activation.
- `in_ready` out 1: block accepts an activation.
- `w_ren` out 1: weight memory read enable.
- `w_radd` out `addressWidth`: weight memory read address.
- `w_rdata` in `dataWidth`: weight memory data, valid one cycle after a `w_ren` edge.
- `out_valid` out 1: one-cycle pulse, result valid.
- `out_data` out `dataWidth`: saturated neuron sum, held until the next result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `start` → RUN. On that edge clear the accumulator, the index and the pipeline valids.
  - RUN: `in_ready`=1. Accept = `in_valid && in_ready`. After the accept with index = `numWeight`-1, go to DRAIN.
  - DRAIN: `in_ready`=0. Wait until pipeline stages 1 and 2 are empty, then go to DONE.
  - DONE: register the result and pulse `out_valid`, then go to IDLE.
- `w_ren` = accept, combinational. `w_radd` = index register. The index increments only on accept and is never advanced past `numWeight`-1.
- The weight memory has no reset. `w_rdata` is used only when the stage-0 valid bit is set and is ignored otherwise.
- Pipeline:
  - Stage 0 at the accept edge: register `in_data` as x_d and set v0.
  - Stage 1: prod <= signed(x_d) * signed(w_rdata), full 2·`dataWidth` bits; v1 <= v0.
  - Stage 2: if v1, acc <= acc + sign-extended prod.
- Accumulator width: 2·`dataWidth` + `addressWidth`. No overflow is possible inside the accumulator.
- Result: acc arithmetic-shifted right by `fracBits`, which floors.
  - Above 2^(`dataWidth`-1)-1, clamp to `0x7FFF`.
  - Below -2^(`dataWidth`-1), clamp to `0x8000`.
  - Otherwise take the low `dataWidth` bits.
- `start` outside IDLE is ignored. `in_valid` outside RUN is ignored and is never accepted.

## Timing
- Reset values, applied immediately and asynchronously: state IDLE, `in_ready`=0, `w_ren`=0, `w_radd`=0, `out_valid`=0, `out_data`=0, `busy`=0, accumulator, index and valid bits all 0.
- Reset in any state aborts the evaluation with no `out_valid`. The next `start` behaves as after power-up.
- `busy` goes high on the clock after the edge that samples `start`. `in_ready` goes high on the same cycle.
- Let edge E0 be the edge that accepts the last input:
  - prod is registered at E1.
  - acc is final at E2.
  - `out_data` is registered at E3, with `out_valid` high for exactly the cycle after E3.
- Latency is therefore 3 cycles from the last accept to `out_valid`. With continuous `in_valid`, an evaluation takes `numWeight`+4 cycles from `start`.
- Gaps in `in_valid` only stall acceptance. The result is unchanged.
- The block returns to IDLE on the same edge that raises `out_valid`. `start` sampled in the `out_valid` cycle is therefore accepted, giving back-to-back evaluations. `out_data` stays valid for the consumer until the next result.

## Test plan
- `numWeight`=4, all weights `0x1000`, inputs `0x1000`,`0x0800`,`0x0400`,`0x0200` back-to-back → `out_data`=`0x1E00`. `out_valid` is high for one cycle exactly 3 cycles after the last accept. `w_radd` sequence is 0,1,2,3.
- Weights `0xF000`,`0x1000`,`0xF000`,`0x1000`; inputs `0x1000`,`0x2000`,`0x0800`,`0x0400` → `0x0C00` (0.75).
- Saturation:
  - Weights and inputs all `0x7FFF` → `0x7FFF`.
  - Weights `0x8000`, inputs `0x7FFF` → `0x8000`.
- `in_valid` toggled randomly with gaps up to 5 cycles → same results as the gapless runs. `w_ren` is asserted only on accepts and never while in IDLE, DRAIN or DONE.
- `start` pulsed while `busy` → ignored and the result is unaffected. `start` in the `out_valid` cycle → the new evaluation begins, the accumulator is cleared, and the second result is correct.
- `rst_n` low after 2 accepts → all outputs are 0 immediately, with no `out_valid`. A following `start` with the first scenario's stimulus → `0x1E00`.

Source files
------------

// File: rtl/neuron_weight_reader.sv
// Single-neuron weight reader and MAC: one activation per handshake, one weight read per accept,
// accumulates x*w and emits a floored, saturated fixed-point sum after numWeight inputs.
module neuron_weight_reader #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int fracBits     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_rdata,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic                    busy
);

  localparam int accWidth  = 2 * dataWidth + addressWidth;
  localparam int prodWidth = 2 * dataWidth;
  localparam logic signed [accWidth-1:0] satMax = (accWidth'(1) <<< (dataWidth - 1)) - accWidth'(1);
  localparam logic signed [accWidth-1:0] satMin = ~satMax;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                         state_reg, state_next;
  logic [addressWidth-1:0]        index_reg;
  logic signed [dataWidth-1:0]    x_reg;
  logic                           v0_reg, v1_reg;
  logic signed [prodWidth-1:0]    prod_reg;
  logic signed [accWidth-1:0]     acc_reg;
  logic [dataWidth-1:0]           out_data_reg;
  logic                           out_valid_reg;

  logic                           accept;
  logic                           last_index;
  logic                           start_eval;
  logic signed [accWidth-1:0]     shifted;
  logic [dataWidth-1:0]           sat_value;

  assign accept     = in_valid && (state_reg == RUN);
  assign last_index = (index_reg == addressWidth'(numWeight - 1));
  assign start_eval = (state_reg == IDLE) && start;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (accept && last_index) state_next = DRAIN;
      // Once v0 is clear, the last product reaches acc on this same edge, so DONE sees the final sum.
      DRAIN: if (!v0_reg) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shifted = acc_reg >>> fracBits;
    if (shifted > satMax)
      sat_value = {1'b0, {(dataWidth-1){1'b1}}};
    else if (shifted < satMin)
      sat_value = {1'b1, {(dataWidth-1){1'b0}}};
    else
      sat_value = shifted[dataWidth-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      x_reg         <= '0;
      v0_reg        <= 1'b0;
      v1_reg        <= 1'b0;
      prod_reg      <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_reg == DONE);
      if (state_reg == DONE)
        out_data_reg <= sat_value;
      if (start_eval) begin
        acc_reg   <= '0;
        index_reg <= '0;
        v0_reg    <= 1'b0;
        v1_reg    <= 1'b0;
      end else begin
        v0_reg <= accept;
        if (accept)
          x_reg <= $signed(in_data);
        if (accept && !last_index)
          index_reg <= index_reg + 1'b1;
        // The weight memory has no reset, so w_rdata is only looked at when v0 marks it as live.
        v1_reg <= v0_reg;
        if (v0_reg)
          prod_reg <= x_reg * $signed(w_rdata);
        if (v1_reg)
          acc_reg <= acc_reg + {{addressWidth{prod_reg[prodWidth-1]}}, prod_reg};
      end
    end
  end

  assign in_ready  = (state_reg == RUN);
  assign w_ren     = accept;
  assign w_radd    = index_reg;
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_neuron_weight_reader.sv
// Bench for neuron_weight_reader with numWeight=4: table vectors, randomized runs against a
// plain-arithmetic model, plus back-to-back, start-while-busy and mid-evaluation reset sequences.
module tb_neuron_weight_reader;
  localparam int NW = 4;
  localparam int AW = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          w_ren;
  logic [AW-1:0] w_radd;
  logic [DW-1:0] w_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;

  neuron_weight_reader #(.numWeight(NW), .dataWidth(DW), .fracBits(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w_ren(w_ren), .w_radd(w_radd), .w_rdata(w_rdata),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [DW-1:0] arr_t [NW];
  typedef struct {
    arr_t          w;
    arr_t          x;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs [4];
  arr_t mem;
  int applied = 0;
  int miscompares = 0;
  int bad_wren = 0;
  logic [AW-1:0] radd_q [$];

  // Weight memory with registered output and no reset
  always @(posedge clk)
    if (w_ren) w_rdata <= mem[w_radd];

  always @(negedge clk)
    if (rst_n) begin
      if (w_ren) radd_q.push_back(w_radd);
      if (w_ren && !(in_valid && in_ready && busy)) bad_wren++;
    end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input arr_t w, input arr_t x);
    longint s = 0;
    for (int i = 0; i < NW; i++)
      s += longint'($signed(w[i])) * longint'($signed(x[i]));
    s = s >>> 12;
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic radd_seq_ok();
    if (radd_q.size() != NW) return 1'b0;
    for (int i = 0; i < NW; i++)
      if (radd_q[i] != AW'(i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed(input arr_t x, input int gapmax, input bit start_mid);
    radd_q.delete();
    for (int i = 0; i < NW; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = x[i];
      if (start_mid && i == NW / 2) start = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  // Called just after the last accept edge; garbage in_valid during drain must be ignored.
  task automatic wait_result(input string name, input logic [DW-1:0] exp, input bit chain);
    int  c = 0;
    bit  seen = 0;
    in_valid = 1'b1;
    in_data  = 16'h7fff;
    while (!seen && c < 12) begin
      @(negedge clk);
      c++;
      seen = out_valid;
    end
    in_valid = 1'b0;
    if (chain) start = 1'b1;
    $display("%s: out_data=%h expected=%h latency=%0d", name, out_data, exp, c);
    check({name, " latency"}, 64'(c), 64'd4);
    check({name, " out_data"}, 64'(out_data), 64'(exp));
    check({name, " w_radd seq"}, 64'(radd_seq_ok()), 64'd1);
    check({name, " w_ren guard"}, 64'(bad_wren), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({name, " pulse width"}, 64'(out_valid), 64'd0);
    check({name, " held"}, 64'(out_data), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    arr_t rw, rx;
    int   ov;
    vecs[0] = '{w: '{16'h1000, 16'h1000, 16'h1000, 16'h1000},
                x: '{16'h1000, 16'h0800, 16'h0400, 16'h0200}, exp: 16'h1e00, name: "halves"};
    vecs[1] = '{w: '{16'hf000, 16'h1000, 16'hf000, 16'h1000},
                x: '{16'h1000, 16'h2000, 16'h0800, 16'h0400}, exp: 16'h0c00, name: "mixed_sign"};
    vecs[2] = '{w: '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff},
                x: '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff}, exp: 16'h7fff, name: "sat_pos"};
    vecs[3] = '{w: '{16'h8000, 16'h8000, 16'h8000, 16'h8000},
                x: '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff}, exp: 16'h8000, name: "sat_neg"};
    mem = vecs[0].w;

    // Reset state, with in_valid high to show it is not accepted
    in_valid = 1'b1;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset w_ren", 64'(w_ren), 64'd0);
    check("reset w_radd", 64'(w_radd), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int pass = 0; pass < 2; pass++)
      for (int v = 0; v < 4; v++) begin
        mem = vecs[v].w;
        do_start();
        if (pass == 0 && v == 0) begin
          check("busy after start", 64'(busy), 64'd1);
          check("in_ready after start", 64'(in_ready), 64'd1);
        end
        feed(vecs[v].x, pass == 0 ? 0 : 5, 1'b0);
        wait_result({vecs[v].name, pass == 0 ? " gapless" : " gapped"}, vecs[v].exp, 1'b0);
      end

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < NW; i++) begin
        rw[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h3fff) - 32'h2000);
        rx[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h3fff) - 32'h2000);
      end
      mem = rw;
      do_start();
      feed(rx, 5, (r % 3) == 0);
      wait_result($sformatf("random %0d", r), model(rw, rx), 1'b0);
    end

    // Back-to-back: start sampled in the out_valid cycle
    mem = vecs[0].w;
    do_start();
    feed(vecs[0].x, 0, 1'b1);
    wait_result("b2b first", 16'h1e00, 1'b1);
    mem = vecs[1].w;
    feed(vecs[1].x, 0, 1'b0);
    wait_result("b2b second", 16'h0c00, 1'b0);

    // Reset after two accepts aborts the evaluation
    mem = vecs[0].w;
    do_start();
    in_valid = 1'b1;
    in_data  = vecs[0].x[0];
    @(posedge clk);
    #1 in_data = vecs[0].x[1];
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd0);
    check("abort w_ren", 64'(w_ren), 64'd0);
    check("abort w_radd", 64'(w_radd), 64'd0);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    ov = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ov++;
    end
    check("abort no out_valid", 64'(ov), 64'd0);
    do_start();
    feed(vecs[0].x, 0, 1'b0);
    wait_result("after reset", 16'h1e00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
